// File: rtl/tdm_demux.sv
// Receive side of the N-to-1 TDM serial link: locks to the frame-sync strobe,
// gathers one bit per slot and presents each complete frame in parallel.
module tdm_demux #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         en,
    input  logic         din,
    input  logic         fsync,
    output logic [N-1:0] y,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   asm_q, asm_d;
    logic [N-1:0]   y_q, y_d;
    logic           fv_q, fv_d;
    logic           err_q, err_d;

    logic           last_slot_s;

    assign last_slot_s = (cnt_q == CW'(N - 1));

    // State, slot counter and assembly register
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    // Next-state: any fsync (re)starts a frame with din as bit 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (fsync) begin
                        asm_d   = {{(N-1){1'b0}}, din};
                        cnt_d   = CW'(1);
                        state_d = LOCKED;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (fsync) begin
                        asm_d = {{(N-1){1'b0}}, din};
                        cnt_d = CW'(1);
                    end else if (cnt_q == CW'(0)) begin
                        state_d = HUNT;
                        cnt_d   = CW'(0);
                    end else if (last_slot_s) begin
                        cnt_d = CW'(0);
                    end else begin
                        asm_d[cnt_q] = din;
                        cnt_d        = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = CW'(0);
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode: completion only on an error-free last slot
    always_comb begin
        y_d   = y_q;
        fv_d  = 1'b0;
        err_d = 1'b0;
        if (en && (state_q == LOCKED)) begin
            if (fsync) begin
                err_d = (cnt_q != CW'(0));
            end else if (cnt_q == CW'(0)) begin
                err_d = 1'b1;
            end else if (last_slot_s) begin
                y_d  = {din, asm_q[N-2:0]};
                fv_d = 1'b1;
            end else begin
                fv_d = 1'b0;
            end
        end else begin
            fv_d = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            y_q   <= '0;
            fv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            fv_q  <= fv_d;
            err_q <= err_d;
        end
    end

    assign y           = y_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized and directed bench for tdm_demux against a queue-based frame model.
module tb_tdm_demux;

    localparam int N = 4;

    logic         CLK;
    logic         N_RESET;
    logic         en;
    logic         din;
    logic         fsync;
    logic [N-1:0] y;
    logic         frame_valid;
    logic         locked;
    logic         sync_err;

    int n_vec;
    int n_err;

    // Reference model state
    bit           m_locked;
    bit           m_bits[$];
    logic [N-1:0] exp_y;
    logic         exp_fv;
    logic         exp_err;

    tdm_demux #(.N(N)) dut (
        .CLK         (CLK),
        .N_RESET     (N_RESET),
        .en          (en),
        .din         (din),
        .fsync       (fsync),
        .y           (y),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y"},           32'(y),           32'(exp_y));
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(exp_fv));
        chk({tag, ".locked"},      32'(locked),      32'(m_locked));
        chk({tag, ".sync_err"},    32'(sync_err),    32'(exp_err));
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_bits.delete();
        exp_y    = '0;
        exp_fv   = 1'b0;
        exp_err  = 1'b0;
    endtask

    // The frame position is simply how many bits are already collected
    task automatic model_clk(input bit e, input bit f, input bit d);
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (e) begin
            if (!m_locked) begin
                if (f) begin
                    m_locked = 1'b1;
                    m_bits.delete();
                    m_bits.push_back(d);
                end
            end else if (f) begin
                if (m_bits.size() != 0) exp_err = 1'b1;
                m_bits.delete();
                m_bits.push_back(d);
            end else if (m_bits.size() == 0) begin
                exp_err  = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == N) begin
                    for (int k = 0; k < N; k++) exp_y[k] = m_bits[k];
                    exp_fv = 1'b1;
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic step(input string tag, input bit e, input bit f, input bit d);
        @(negedge CLK);
        en    = e;
        fsync = f;
        din   = d;
        @(posedge CLK);
        model_clk(e, f, d);
        #1;
        check_all(tag);
    endtask

    task automatic send_frame(input string tag, input logic [N-1:0] frame, input int gaps);
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < gaps; g++) step(tag, 1'b0, 1'($urandom), 1'($urandom));
            step(tag, 1'b1, (k == 0), frame[k]);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        en      = 1'b0;
        din     = 1'b0;
        fsync   = 1'b0;
        N_RESET = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        @(negedge CLK);
        N_RESET = 1'b1;

        // Basic frames, back-to-back
        send_frame("frame1001", 4'b1001, 0);
        send_frame("b2b_1001", 4'b1001, 0);
        send_frame("b2b_0110", 4'b0110, 0);

        // Sparse en
        send_frame("sparse_en", 4'b1001, 2);
        step("sparse_idle", 1'b0, 1'b1, 1'b1);

        // Early sync at slot 2, then frame 0110 starting at that fsync
        send_frame("pre_early", 4'b1001, 0);
        step("early_s0", 1'b1, 1'b1, 1'b1);
        step("early_s1", 1'b1, 1'b0, 1'b0);
        step("early_sync", 1'b1, 1'b1, 1'b0);
        step("early_s1b", 1'b1, 1'b0, 1'b1);
        step("early_s2b", 1'b1, 1'b0, 1'b1);
        step("early_s3b", 1'b1, 1'b0, 1'b0);

        // Early sync landing on the last slot
        step("late_s0", 1'b1, 1'b1, 1'b1);
        step("late_s1", 1'b1, 1'b0, 1'b1);
        step("late_s2", 1'b1, 1'b0, 1'b1);
        step("late_sync", 1'b1, 1'b1, 1'b0);
        step("late_s1b", 1'b1, 1'b0, 1'b0);
        step("late_s2b", 1'b1, 1'b0, 1'b1);
        step("late_s3b", 1'b1, 1'b0, 1'b1);

        // Missing sync drops lock; din ignored until the next fsync
        step("miss_sync", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step("hunt_ignore", 1'b1, 1'b0, 1'(i));
        send_frame("relock", 4'b1001, 0);

        // Asynchronous reset mid-frame
        step("rst_s0", 1'b1, 1'b1, 1'b0);
        step("rst_s1", 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        #2;
        N_RESET = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge CLK);
        N_RESET = 1'b1;
        send_frame("post_rst", 4'b1111, 0);

        // Randomized traffic: mostly aligned frames with occasional faults
        for (int i = 0; i < 400; i++) begin
            bit e;
            bit f;
            e = ($urandom_range(0, 3) != 0);
            if (m_bits.size() == 0) f = ($urandom_range(0, 9) != 0);
            else                    f = ($urandom_range(0, 19) == 0);
            step("rand", e, f, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
